// File: rtl/memctrl_rr_arbiter.sv
// memctrl_rr_arbiter: round-robin arbiter sharing one MEMCTRL port among NREQ
// requesters. Each access is one ACCESS cycle followed by one RECOVER cycle.
// Read data is returned RD_LAT+1 cycles after ACCESS on the shared RSP_RDATA bus.
// Optional feature macro: MEMCTRL_ARB_BANK_SKIP_EN (back-to-back ACCESS to a
// different bank, skipping RECOVER).
module memctrl_rr_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [NREQ-1:0]      REQ_VLD,
  input  logic [NREQ-1:0]      REQ_WE,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  input  logic [NREQ*DW-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      REQ_RDY,
  output logic [NREQ-1:0]      RSP_VLD,
  output logic [DW-1:0]        RSP_RDATA,
  output logic [AW-1:0]        ADDR,
  output logic                 CE,
  output logic                 CSB,
  output logic                 OEB,
  output logic                 WEB,
  output logic [DW-1:0]        IDATA,
  input  logic [DW-1:0]        ODATA
);

  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   acc_id;
  logic            found;
  logic            arb_en;
  logic            accept;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            win_we;
  logic [RD_LAT-1:0]        pipe_vld;
  logic [IW-1:0]            pipe_id [RD_LAT];

  // Round-robin search: first valid requester starting at ptr+1, wrapping.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (!found && REQ_VLD[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_addr  = REQ_ADDR[win*AW +: AW];
  assign win_wdata = REQ_WDATA[win*DW +: DW];
  assign win_we    = REQ_WE[win];

`ifdef MEMCTRL_ARB_BANK_SKIP_EN
  // In ACCESS, ADDR still holds the bank being accessed; a different bank may follow at once.
  assign arb_en = (state != ACCESS) || (win_addr[AW-1:AW-2] != ADDR[AW-1:AW-2]);
`else
  assign arb_en = (state != ACCESS);
`endif

  // Gated by RSTN so no grant is offered while reset is held.
  assign accept = RSTN && found && arb_en;

  // One-hot ready for the accepted winner.
  always_comb begin
    REQ_RDY = '0;
    if (accept) REQ_RDY = NREQ'(1) << win;
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: any acceptance starts an ACCESS; ACCESS otherwise recovers.
  always_comb begin
    state_nxt = IDLE;
    if (accept)                state_nxt = ACCESS;
    else if (state == ACCESS)  state_nxt = RECOVER;
  end

  // Pointer and MEMCTRL strobes; strobes are valid in the cycle after acceptance.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr    <= IW'(NREQ - 1);
      acc_id <= '0;
      ADDR   <= '0;
      IDATA  <= '0;
      CE     <= 1'b0;
      CSB    <= 1'b1;
      OEB    <= 1'b1;
      WEB    <= 1'b1;
    end else if (accept) begin
      ptr    <= win;
      acc_id <= win;
      ADDR   <= win_addr;
      IDATA  <= win_we ? win_wdata : '0;
      CE     <= 1'b1;
      CSB    <= 1'b0;
      OEB    <= win_we;
      WEB    <= ~win_we;
    end else begin
      IDATA  <= '0;
      CE     <= 1'b0;
      CSB    <= 1'b1;
      OEB    <= 1'b1;
      WEB    <= 1'b1;
    end
  end

  // Read tag pipeline; the last stage marks the edge that samples ODATA.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pipe_vld <= '0;
      for (int unsigned j = 0; j < RD_LAT; j++) pipe_id[j] <= '0;
      RSP_VLD   <= '0;
      RSP_RDATA <= '0;
    end else begin
      pipe_vld[0] <= CE && !OEB;
      pipe_id[0]  <= acc_id;
      for (int unsigned j = 1; j < RD_LAT; j++) begin
        pipe_vld[j] <= pipe_vld[j-1];
        pipe_id[j]  <= pipe_id[j-1];
      end
      if (pipe_vld[RD_LAT-1]) begin
        RSP_VLD   <= NREQ'(1) << pipe_id[RD_LAT-1];
        RSP_RDATA <= ODATA;
      end else begin
        RSP_VLD   <= '0;
      end
    end
  end

endmodule
